// File: rtl/setup_menu_n.sv
// setup_menu_n: operator configuration menu for the lock controller.
// Walks beep enable, beep time, auto-lock time, master PIN and N_USER user
// PINs, editing a working copy that is published to the committed
// configuration only on save; abort or inactivity timeout discards it.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   setup_on            menu entry request (honoured only in IDLE)
//   digitos_value/valid 20-digit BCD keypad frame (digit 0 = last key) + strobe
//   display_en, bcd_pac display ownership and six BCD digits (BCD0 at [3:0])
//   cfg_*               committed configuration
//   data_setup_ok       one-cycle pulse in COMMIT
//   setup_abort         one-cycle pulse in ABORT
module setup_menu_n #(
  parameter int unsigned N_USER      = 4,
  parameter int unsigned PIN_MIN     = 4,
  parameter int unsigned PIN_MAX     = 12,
  parameter int unsigned T_MIN       = 5,
  parameter int unsigned T_MAX       = 60,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         setup_on,
  input  logic [79:0]                  digitos_value,
  input  logic                         digitos_valid,
  output logic                         display_en,
  output logic [23:0]                  bcd_pac,
  output logic                         cfg_bip_status,
  output logic [6:0]                   cfg_bip_time,
  output logic [6:0]                   cfg_trc_time,
  output logic [4*PIN_MAX-1:0]         cfg_master,
  output logic [4*N_USER*PIN_MAX-1:0]  cfg_user,
  output logic                         data_setup_ok,
  output logic                         setup_abort
);

  localparam int unsigned N_DIG = 20;
  localparam int unsigned FW    = 4 * N_DIG;
  localparam int unsigned PW    = 4 * PIN_MAX;
  localparam int unsigned UW    = N_USER * PW;
  localparam int unsigned IDX_W = $clog2(N_USER + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);

  localparam logic [FW-1:0] FRAME_F    = {N_DIG{4'hF}};
  localparam logic [FW-1:0] FRAME_B    = {N_DIG{4'hB}};
  localparam logic [FW-1:0] FRAME_E    = {N_DIG{4'hE}};
  localparam logic [PW-1:0] MASTER_DEF = ({PW{1'b1}} << 16) | PW'(16'h1234);
  localparam logic [UW-1:0] USER_DEF   = {UW{1'b1}};
  localparam logic [6:0]    TIME_DEF   = 7'(T_MIN);

  typedef enum logic [2:0] {
    S_IDLE, S_BIP_EN, S_BIP_TIME, S_TRC_TIME, S_PIN, S_COMMIT, S_ABORT
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic               err, err_n;

  logic               w_bip_status, w_bip_status_n;
  logic [6:0]         w_bip_time, w_bip_time_n;
  logic [6:0]         w_trc_time, w_trc_time_n;
  logic [PW-1:0]      w_master, w_master_n;
  logic [UW-1:0]      w_user, w_user_n;

  logic               c_bip_status_n;
  logic [6:0]         c_bip_time_n, c_trc_time_n;
  logic [PW-1:0]      c_master_n;
  logic [UW-1:0]      c_user_n;

  // PIN frame: contiguous digits from digit 0, length in range, all BCD,
  // nothing but F above the PIN.
  function automatic logic pin_valid(input logic [FW-1:0] f);
    int   len;
    logic run;
    logic ok;
    len = 0;
    run = 1'b1;
    ok  = 1'b1;
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (run && f[i*4 +: 4] != 4'hF) len++;
      else run = 1'b0;
    end
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (i >= len && f[i*4 +: 4] != 4'hF) ok = 1'b0;
      if (i < len && f[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok && (len >= int'(PIN_MIN)) && (len <= int'(PIN_MAX));
  endfunction

  function automatic logic [6:0] clamp_t(input logic [6:0] v);
    if (v < 7'(T_MIN)) return 7'(T_MIN);
    if (v > 7'(T_MAX)) return 7'(T_MAX);
    return v;
  endfunction

  // Frame decode shared by all menu fields
  logic          frame_f, frame_b, frame_e;
  logic          bip_ok, t_ok, pin_ok;
  logic [3:0]    d0, d1;
  logic [6:0]    t_val;
  logic [PW-1:0] pin_field;

  assign frame_f   = (digitos_value == FRAME_F);
  assign frame_b   = (digitos_value == FRAME_B);
  assign frame_e   = (digitos_value == FRAME_E);
  assign d0        = digitos_value[3:0];
  assign d1        = (digitos_value[7:4] == 4'hF) ? 4'h0 : digitos_value[7:4];
  assign bip_ok    = (d0 == 4'h0) || (d0 == 4'h1);
  assign t_ok      = (d1 <= 4'd9) && (d0 <= 4'd9);
  assign t_val     = clamp_t(7'(d1) * 7'd10 + 7'(d0));
  assign pin_ok    = pin_valid(digitos_value);
  assign pin_field = digitos_value[PW-1:0];

  // Next-state, working copy and commit logic
  always_comb begin
    state_n        = state;
    idx_n          = idx;
    err_n          = err;
    timer_n        = timer;
    w_bip_status_n = w_bip_status;
    w_bip_time_n   = w_bip_time;
    w_trc_time_n   = w_trc_time;
    w_master_n     = w_master;
    w_user_n       = w_user;
    c_bip_status_n = cfg_bip_status;
    c_bip_time_n   = cfg_bip_time;
    c_trc_time_n   = cfg_trc_time;
    c_master_n     = cfg_master;
    c_user_n       = cfg_user;

    case (state)
      S_IDLE: begin
        timer_n = '0;
        if (setup_on) begin
          state_n        = S_BIP_EN;
          idx_n          = '0;
          err_n          = 1'b0;
          w_bip_status_n = cfg_bip_status;
          w_bip_time_n   = cfg_bip_time;
          w_trc_time_n   = cfg_trc_time;
          w_master_n     = cfg_master;
          w_user_n       = cfg_user;
        end
      end
      S_COMMIT, S_ABORT: begin
        timer_n = '0;
        state_n = S_IDLE;
      end
      default: begin
        if (digitos_valid) begin
          timer_n = '0;
          if (frame_b) begin
            err_n   = 1'b0;
            state_n = S_COMMIT;
          end else if (frame_e) begin
            err_n   = 1'b0;
            state_n = S_ABORT;
          end else begin
            case (state)
              S_BIP_EN: begin
                if (frame_f || bip_ok) begin
                  err_n   = 1'b0;
                  state_n = S_BIP_TIME;
                  if (!frame_f) w_bip_status_n = d0[0];
                end else begin
                  err_n = 1'b1;
                end
              end
              S_BIP_TIME, S_TRC_TIME: begin
                if (frame_f || t_ok) begin
                  err_n = 1'b0;
                  if (state == S_BIP_TIME) begin
                    state_n = S_TRC_TIME;
                    if (!frame_f) w_bip_time_n = t_val;
                  end else begin
                    state_n = S_PIN;
                    idx_n   = '0;
                    if (!frame_f) w_trc_time_n = t_val;
                  end
                end else begin
                  err_n = 1'b1;
                end
              end
              default: begin
                if (frame_f || pin_ok) begin
                  err_n = 1'b0;
                  if (pin_ok) begin
                    if (idx == '0) w_master_n = pin_field;
                    for (int k = 0; k < int'(N_USER); k++) begin
                      if (idx == IDX_W'(k + 1)) w_user_n[k*PW +: PW] = pin_field;
                    end
                  end
                  if (idx == IDX_W'(N_USER)) state_n = S_COMMIT;
                  else idx_n = idx + IDX_W'(1);
                end else begin
                  err_n = 1'b1;
                end
              end
            endcase
          end
        end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
          state_n = S_ABORT;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
    endcase

    // Publish on the edge into COMMIT so the new values are visible in COMMIT
    if (state_n == S_COMMIT) begin
      c_bip_status_n = w_bip_status_n;
      c_bip_time_n   = w_bip_time_n;
      c_trc_time_n   = w_trc_time_n;
      c_master_n     = w_master_n;
      c_user_n       = w_user_n;
    end
  end

  // State, working copy, committed config and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      timer          <= '0;
      err            <= 1'b0;
      w_bip_status   <= 1'b1;
      w_bip_time     <= TIME_DEF;
      w_trc_time     <= TIME_DEF;
      w_master       <= MASTER_DEF;
      w_user         <= USER_DEF;
      cfg_bip_status <= 1'b1;
      cfg_bip_time   <= TIME_DEF;
      cfg_trc_time   <= TIME_DEF;
      cfg_master     <= MASTER_DEF;
      cfg_user       <= USER_DEF;
      display_en     <= 1'b0;
      data_setup_ok  <= 1'b0;
      setup_abort    <= 1'b0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      timer          <= timer_n;
      err            <= err_n;
      w_bip_status   <= w_bip_status_n;
      w_bip_time     <= w_bip_time_n;
      w_trc_time     <= w_trc_time_n;
      w_master       <= w_master_n;
      w_user         <= w_user_n;
      cfg_bip_status <= c_bip_status_n;
      cfg_bip_time   <= c_bip_time_n;
      cfg_trc_time   <= c_trc_time_n;
      cfg_master     <= c_master_n;
      cfg_user       <= c_user_n;
      display_en     <= (state_n != S_IDLE);
      data_setup_ok  <= (state_n == S_COMMIT);
      setup_abort    <= (state_n == S_ABORT);
    end
  end

  // Display: field number, error mark, and live echo of the keypad frame
  always_comb begin
    bcd_pac = {6{4'hB}};
    case (state)
      S_BIP_EN: begin
        bcd_pac[23:20] = 4'h1;
        bcd_pac[3:0]   = digitos_value[3:0];
        if (err) bcd_pac[19:16] = 4'hE;
      end
      S_BIP_TIME: begin
        bcd_pac[23:20] = 4'h2;
        bcd_pac[7:0]   = digitos_value[7:0];
        if (err) bcd_pac[19:16] = 4'hE;
      end
      S_TRC_TIME: begin
        bcd_pac[23:20] = 4'h3;
        bcd_pac[7:0]   = digitos_value[7:0];
        if (err) bcd_pac[19:16] = 4'hE;
      end
      S_PIN: begin
        bcd_pac[23:20] = 4'(idx) + 4'd4;
        if (err) bcd_pac[19:16] = 4'hE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_setup_menu_n.sv
// Directed self-checking bench for setup_menu_n (N_USER=4, PIN 4..12,
// times 5..60, short inactivity timeout).
module tb_setup_menu_n;

  localparam int unsigned TO = 20;

  localparam logic [79:0] FR_F = {20{4'hF}};
  localparam logic [79:0] FR_B = {20{4'hB}};
  localparam logic [79:0] FR_E = {20{4'hE}};
  localparam logic [47:0] M_DEF = 48'hFFFF_FFFF_1234;
  localparam logic [47:0] P1111 = 48'hFFFF_FFFF_1111;

  logic         clk;
  logic         rst;
  logic         setup_on;
  logic [79:0]  digitos_value;
  logic         digitos_valid;
  logic         display_en;
  logic [23:0]  bcd_pac;
  logic         cfg_bip_status;
  logic [6:0]   cfg_bip_time;
  logic [6:0]   cfg_trc_time;
  logic [47:0]  cfg_master;
  logic [191:0] cfg_user;
  logic         data_setup_ok;
  logic         setup_abort;

  int n_checks = 0;
  int n_pass   = 0;

  setup_menu_n #(.TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .setup_on       (setup_on),
    .digitos_value  (digitos_value),
    .digitos_valid  (digitos_valid),
    .display_en     (display_en),
    .bcd_pac        (bcd_pac),
    .cfg_bip_status (cfg_bip_status),
    .cfg_bip_time   (cfg_bip_time),
    .cfg_trc_time   (cfg_trc_time),
    .cfg_master     (cfg_master),
    .cfg_user       (cfg_user),
    .data_setup_ok  (data_setup_ok),
    .setup_abort    (setup_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Frame with the low n digits taken from d, the rest F
  function automatic logic [79:0] mk(input logic [63:0] d, input int n);
    logic [79:0] f;
    f = FR_F;
    for (int i = 0; i < n; i++) f[i*4 +: 4] = d[i*4 +: 4];
    return f;
  endfunction

  // Called at a negedge; returns at the negedge after the capturing edge
  task automatic send(input logic [79:0] f);
    digitos_value = f;
    digitos_valid = 1'b1;
    @(negedge clk);
    digitos_valid = 1'b0;
  endtask

  task automatic enter();
    setup_on = 1'b1;
    @(negedge clk);
    setup_on = 1'b0;
  endtask

  task automatic check_defaults(input string tag);
    check({tag, "_master"}, 256'(cfg_master), 256'(M_DEF));
    check({tag, "_user"}, 256'(cfg_user), 256'({192{1'b1}}));
    check({tag, "_btime"}, 256'(cfg_bip_time), 256'(7'd5));
    check({tag, "_ttime"}, 256'(cfg_trc_time), 256'(7'd5));
    check({tag, "_bstat"}, 256'(cfg_bip_status), 256'(1'b1));
    check({tag, "_bcd"}, 256'(bcd_pac), 256'(24'hBBBBBB));
    check({tag, "_disp"}, 256'(display_en), 256'(1'b0));
    check({tag, "_flags"}, 256'({data_setup_ok, setup_abort}), 256'(2'b00));
  endtask

  initial begin
    rst = 1'b0;
    setup_on = 1'b0;
    digitos_value = FR_F;
    digitos_valid = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check_defaults("rst");
    rst = 1'b0;
    @(negedge clk);

    // Full edit path
    enter();
    check("full_f1", 256'(bcd_pac[23:16]), 256'(8'h1B));
    check("full_disp", 256'(display_en), 256'(1'b1));
    send(mk(64'h1, 1));
    check("full_f2", 256'(bcd_pac), 256'(24'h2BBBF1));
    send(mk(64'h45, 2));
    check("full_f3", 256'(bcd_pac), 256'(24'h3BBB45));
    send(mk(64'h07, 2));
    check("full_f4", 256'(bcd_pac), 256'(24'h4BBBBB));
    send(mk(64'h9876, 4));
    check("full_f5", 256'(bcd_pac), 256'(24'h5BBBBB));
    send(mk(64'h1111, 4));
    check("full_f6", 256'(bcd_pac), 256'(24'h6BBBBB));
    send(mk(64'h1111, 4));
    check("full_f7", 256'(bcd_pac), 256'(24'h7BBBBB));
    send(mk(64'h1111, 4));
    check("full_f8", 256'(bcd_pac), 256'(24'h8BBBBB));
    check("full_nook", 256'(data_setup_ok), 256'(1'b0));
    check("full_nocommit", 256'(cfg_bip_time), 256'(7'd5));
    send(mk(64'h1111, 4));
    check("full_ok", 256'(data_setup_ok), 256'(1'b1));
    check("full_btime", 256'(cfg_bip_time), 256'(7'd45));
    check("full_ttime", 256'(cfg_trc_time), 256'(7'd7));
    check("full_master", 256'(cfg_master), 256'(48'hFFFF_FFFF_9876));
    check("full_user", 256'(cfg_user), 256'({P1111, P1111, P1111, P1111}));
    check("full_bcd_commit", 256'(bcd_pac), 256'(24'hBBBBBB));
    @(negedge clk);
    check("full_ok_end", 256'(data_setup_ok), 256'(1'b0));
    check("full_idle", 256'(display_en), 256'(1'b0));

    // Rejects and clamps
    enter();
    send(mk(64'h7, 1));
    check("rej_bip", 256'(bcd_pac), 256'(24'h1EBBB7));
    send(mk(64'h0, 1));
    check("bip_ok", 256'(bcd_pac), 256'(24'h2BBBF0));
    send(mk(64'h1A, 2));
    check("rej_time", 256'(bcd_pac), 256'(24'h2EBB1A));
    send(mk(64'h99, 2));
    check("time99", 256'(bcd_pac), 256'(24'h3BBB99));
    send(mk(64'h02, 2));
    check("time02", 256'(bcd_pac), 256'(24'h4BBBBB));
    send(FR_B);
    check("clamp_ok", 256'(data_setup_ok), 256'(1'b1));
    check("clamp_bstat", 256'(cfg_bip_status), 256'(1'b0));
    check("clamp_hi", 256'(cfg_bip_time), 256'(7'd60));
    check("clamp_lo", 256'(cfg_trc_time), 256'(7'd5));
    check("clamp_master", 256'(cfg_master), 256'(48'hFFFF_FFFF_9876));
    @(negedge clk);

    // PIN bounds
    enter();
    send(FR_F);
    send(FR_F);
    send(FR_F);
    check("pin_start", 256'(bcd_pac), 256'(24'h4BBBBB));
    send(mk(64'h123, 3));
    check("pin_short", 256'(bcd_pac), 256'(24'h4EBBBB));
    send(mk(64'h1234567890123, 13));
    check("pin_long", 256'(bcd_pac), 256'(24'h4EBBBB));
    send(mk(64'h1234, 4));
    check("pin_4", 256'(bcd_pac), 256'(24'h5BBBBB));
    send(FR_F);
    check("pin_skip", 256'(bcd_pac), 256'(24'h6BBBBB));
    send(mk(64'h123456789012, 12));
    check("pin_12", 256'(bcd_pac), 256'(24'h7BBBBB));
    send(FR_B);
    check("pin_master", 256'(cfg_master), 256'(M_DEF));
    check("pin_user", 256'(cfg_user),
          256'({P1111, P1111, 48'h1234_5678_9012, P1111}));
    @(negedge clk);

    // Explicit abort
    enter();
    send(FR_F);
    send(mk(64'h30, 2));
    send(FR_E);
    check("abort_pulse", 256'(setup_abort), 256'(1'b1));
    check("abort_nook", 256'(data_setup_ok), 256'(1'b0));
    check("abort_btime", 256'(cfg_bip_time), 256'(7'd60));
    @(negedge clk);
    check("abort_end", 256'({setup_abort, display_en}), 256'(2'b00));

    // Inactivity timeout
    enter();
    repeat (TO - 1) @(negedge clk);
    check("to_not_yet", 256'({setup_abort, bcd_pac[23:20]}), 256'(5'h01));
    @(negedge clk);
    check("to_abort", 256'(setup_abort), 256'(1'b1));
    check("to_btime", 256'(cfg_bip_time), 256'(7'd60));
    @(negedge clk);

    // Strobe on the last cycle wins over the timeout
    enter();
    repeat (TO - 1) @(negedge clk);
    send(FR_F);
    check("to_saved", 256'({setup_abort, bcd_pac[23:20]}), 256'(5'h02));
    send(FR_E);
    @(negedge clk);

    // Asynchronous reset mid-menu at PIN idx 2
    enter();
    send(mk(64'h1, 1));
    send(mk(64'h33, 2));
    send(FR_F);
    send(mk(64'h5555, 4));
    send(FR_F);
    check("ar_idx2", 256'(bcd_pac[23:20]), 256'(4'h6));
    #2 rst = 1'b1;
    #1;
    check_defaults("ar");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    enter();
    check("ar_restart", 256'({display_en, bcd_pac[23:20]}), 256'(5'h11));
    send(FR_B);
    check("ar_wc_btime", 256'(cfg_bip_time), 256'(7'd5));
    check("ar_wc_master", 256'(cfg_master), 256'(M_DEF));
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
